// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: datapath request/response and data-memory port bundle for the load/store unit.
interface dmem_lsu_if #(
    parameter int ADDRW = 10,
    parameter int DATAW = 32
);
    logic             req_i;
    logic             we_i;
    logic [1:0]       size_i;
    logic             unsigned_i;
    logic [ADDRW+1:0] addr_i;
    logic [DATAW-1:0] wdata_i;
    logic             busy_o;
    logic             done_o;
    logic             misalign_o;
    logic [DATAW-1:0] rdata_o;
    logic             mem_re_o;
    logic             mem_we_o;
    logic [ADDRW-1:0] mem_addr_o;
    logic [DATAW-1:0] mem_wdata_o;
    logic [DATAW-1:0] mem_rdata_i;

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_rdata_i,
        output busy_o, done_o, misalign_o, rdata_o, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, mem_rdata_i,
        input  busy_o, done_o, misalign_o, rdata_o, mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte/half/word load-store unit; sub-word stores are read-modify-write.
module dmem_lsu #(
    parameter int ADDRW = 10,
    parameter int DATAW = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    dmem_lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_e;

    state_e           state_q, state_d;
    logic             we_q, uns_q, done_q, done_d, mis_q, mis_d, misalign;
    logic [1:0]       size_q;
    logic [ADDRW+1:0] addr_q;
    logic [DATAW-1:0] wdata_q, merge_q, merge_d, rdata_q, rdata_d, load_val, mask;
    logic [7:0]       byte_ln;
    logic [15:0]      half_ln;
    logic [4:0]       sh;

    assign misalign = (bus.size_i == 2'b01) ? bus.addr_i[0] :
                      bus.size_i[1] ? (bus.addr_i[1:0] != 2'b00) : 1'b0;

    always_comb begin
        sh       = (size_q == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
        byte_ln  = bus.mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        half_ln  = bus.mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        load_val = (size_q == 2'b00) ? {{(DATAW-8){~uns_q & byte_ln[7]}}, byte_ln} :
                   (size_q == 2'b01) ? {{(DATAW-16){~uns_q & half_ln[15]}}, half_ln} :
                   bus.mem_rdata_i;
        mask     = ((size_q == 2'b00) ? DATAW'(32'h0000_00FF) : DATAW'(32'h0000_FFFF)) << sh;
        merge_d  = (bus.mem_rdata_i & ~mask) | ((wdata_q << sh) & mask);
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: if (bus.req_i) begin
                if (misalign) {done_d, mis_d} = 2'b11;
                else state_d = (bus.we_i && bus.size_i[1]) ? WR : RD;
            end
            RD: begin
                state_d = we_q ? WR : IDLE;
                done_d  = ~we_q;
                rdata_d = we_q ? rdata_q : load_val;
            end
            WR: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory port decodes straight from state so an async reset silences it at once.
    assign bus.busy_o      = state_q != IDLE;
    assign bus.mem_re_o    = state_q == RD;
    assign bus.mem_we_o    = state_q == WR;
    assign bus.mem_addr_o  = (state_q != IDLE) ? addr_q[ADDRW+1:2] : '0;
    assign bus.mem_wdata_o = (state_q == WR) ? (size_q[1] ? wdata_q : merge_q) : '0;
    assign bus.done_o      = done_q;
    assign bus.misalign_o  = mis_q;
    assign bus.rdata_o     = rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            merge_q <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            if (state_q == RD && we_q) merge_q <= merge_d;
            if (state_q == IDLE && bus.req_i) begin
                we_q    <= bus.we_i;
                uns_q   <= bus.unsigned_i;
                size_q  <= bus.size_i;
                addr_q  <= bus.addr_i;
                wdata_q <= bus.wdata_i;
            end
        end
    end
endmodule
